// File: rtl/weight_ram_loader.sv
// Write-side loader for the shared BNN weight memory: accepts a valid/ready word
// stream and writes it contiguously through the CONV1..FCL2 regions.
module weight_ram_loader #(
  parameter int          DW         = 1,
  parameter logic [11:0] CONV1_LEN  = 12'd9,
  parameter logic [11:0] CONV23_LEN = 12'd1008,
  parameter logic [11:0] FCL1_LEN   = 12'd672,
  parameter logic [11:0] FCL2_LEN   = 12'd12
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          iSTART,
  input  logic          iVALID,
  input  logic [DW-1:0] iDATA,
  output logic          oREADY,
  output logic          oWE,
  output logic [11:0]   oWADDR,
  output logic [DW-1:0] oWDATA,
  output logic [2:0]    oLAYER,
  output logic          oDONE
);

  localparam logic [1:0] IDLE_ST = 2'd0;
  localparam logic [1:0] LOAD_ST = 2'd1;
  localparam logic [1:0] DONE_ST = 2'd2;

  localparam logic [2:0] L_NONE  = 3'b000;
  localparam logic [2:0] L_CONV1 = 3'b010;
  localparam logic [2:0] L_CONV2 = 3'b011;
  localparam logic [2:0] L_CONV3 = 3'b100;
  localparam logic [2:0] L_FCL1  = 3'b101;
  localparam logic [2:0] L_FCL2  = 3'b110;

  logic [1:0]  state;
  logic [11:0] wr_ptr;
  logic [2:0]  layer;
  logic [9:0]  word_cnt;
  logic [11:0] layer_len;
  logic        xfer;
  logic        last_in_layer;
  logic        last_word;

  assign oREADY = (state == LOAD_ST);
  assign oDONE  = (state == DONE_ST);
  assign xfer   = iVALID & oREADY;

  // Region bases are cumulative lengths, so layer boundaries fall out of the
  // per-layer word count rather than address compares.
  always_comb begin
    layer_len = FCL2_LEN;
    case (layer)
      L_CONV1:          layer_len = CONV1_LEN;
      L_CONV2, L_CONV3: layer_len = CONV23_LEN;
      L_FCL1:           layer_len = FCL1_LEN;
      default:          layer_len = FCL2_LEN;
    endcase
  end

  assign last_in_layer = ({2'b00, word_cnt} == (layer_len - 12'd1));
  assign last_word     = last_in_layer && (layer == L_FCL2);

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state    <= IDLE_ST;
      wr_ptr   <= 12'd0;
      layer    <= L_NONE;
      word_cnt <= 10'd0;
    end else begin
      case (state)
        IDLE_ST, DONE_ST: begin
          if (iSTART) begin
            state    <= LOAD_ST;
            wr_ptr   <= 12'd0;
            layer    <= L_CONV1;
            word_cnt <= 10'd0;
          end
        end
        LOAD_ST: begin
          if (xfer) begin
            wr_ptr <= wr_ptr + 12'd1;
            if (last_in_layer) begin
              word_cnt <= 10'd0;
              // Layer codes are consecutive, so advancing is a simple increment.
              if (last_word) state <= DONE_ST;
              else           layer <= layer + 3'd1;
            end else begin
              word_cnt <= word_cnt + 10'd1;
            end
          end
        end
        default: state <= IDLE_ST;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      oWE    <= 1'b0;
      oWADDR <= 12'd0;
      oWDATA <= '0;
      oLAYER <= L_NONE;
    end else begin
      oWE <= xfer;
      if (xfer) begin
        oWADDR <= wr_ptr;
        oWDATA <= iDATA;
        oLAYER <= layer;
      end
    end
  end

endmodule

// File: doc/weight_ram_loader.md
# weight_ram_loader

Write-side counterpart of the BNN weight ROM address controller. Accepts the binarized weight stream from the host/loader interface word by word through a valid/ready handshake and produces write enable, address and data for the shared 12-bit-addressed weight memory. Fills each layer region in order (CONV1, CONV2, CONV3, FCL1, FCL2) at the same base offsets the read-side controller uses. Reports the current layer and completion.

## Interface
Parameters:
- DW, 1, weight word width in bits.
- CONV1_LEN, 12'd9, CONV1 word count; region base 12'd0.
- CONV23_LEN, 12'd1008, word count of CONV2 and of CONV3; bases 12'd9 and 12'd1017.
- FCL1_LEN, 12'd672, FCL1 word count; base 12'd2025.
- FCL2_LEN, 12'd12, FCL2 word count; base 12'd2697.

Ports:
- iCLK  in  1  clock; all state on rising edge.
- iRSTn  in  1  one clock; reset is asynchronous and active-low.
- iSTART  in  1  start a full load; sampled only in IDLE_ST or DONE_ST.
- iVALID  in  1  iDATA holds a valid weight word.
- iDATA  in  DW  weight word.
- oREADY  out  1  loader accepts a word this cycle.
- oWE  out  1  memory write enable, one cycle per accepted word.
- oWADDR  out  12  memory write address.
- oWDATA  out  DW  memory write data.
- oLAYER  out  3  layer of the word on oWADDR: 010 CONV1, 011 CONV2, 100 CONV3, 101 FCL1, 110 FCL2, 000 otherwise.
- oDONE  out  1  all 2709 words written; level.

## Operation
- States: IDLE_ST, LOAD_ST, DONE_ST.
- IDLE_ST: oREADY=0. iSTART=1 -> LOAD_ST; write address counter and layer register cleared to 0 / CONV1.
- LOAD_ST: oREADY=1 combinationally from state. Transfer = iVALID & oREADY at a rising edge.
- Each transfer: write pointer (12 bits, 0..2708) captured into oWADDR, iDATA into oWDATA, current layer into oLAYER, oWE=1 next cycle; pointer then increments by 1.
- Addresses are contiguous: region bases equal cumulative lengths, so the pointer never jumps. Layer register advances when the pointer crosses 9, 1017, 2025, 2697 (i.e. the transfer at pointer base-1 is the last of the old layer; next transfer is tagged with the new layer).
- Per-layer word counter (10 bits) wraps to 0 at each layer boundary; visible only through oLAYER.
- Transfer at pointer 2708 (last FCL2 word) -> DONE_ST on the same edge; oREADY drops next cycle, so no word beyond 2709 is ever accepted.
- DONE_ST: oDONE=1, oREADY=0; iVALID ignored. iSTART=1 -> LOAD_ST with pointer 0, oDONE=0 next cycle (reload overwrites the whole memory).
- iSTART while in LOAD_ST is ignored; the load is not restarted.
- No transfer cycle in LOAD_ST: oWE=0, oWADDR/oWDATA/oLAYER hold last values.
- Reset at any time: state IDLE_ST, partial load abandoned, no write issued after reset release until a new iSTART.

## Timing
- Reset values: oREADY=0, oWE=0, oWADDR=12'd0, oWDATA=0, oLAYER=3'b000, oDONE=0.
- iSTART at edge N (IDLE) -> oREADY=1 during cycle N+1; earliest transfer at edge N+1.
- Transfer at edge K -> oWE=1, oWADDR/oWDATA/oLAYER valid during cycle K+1 (1-cycle latency); memory captures at edge K+2 edge-aligned with oWE.
- Back-to-back transfers -> oWE stays high continuously, addresses increment every cycle; full uninterrupted load = 2709 cycles of oWE.
- Last transfer at edge L -> oWE with oWADDR=2708 and oDONE=1 both in cycle L+1; oREADY=0 in cycle L+1.
- oLAYER changes only together with an oWE pulse (or on reset).

## Test plan
- Reset, iSTART, 2709 contiguous words (iDATA = addr[0]) -> oWADDR 0..2708 in order, one oWE each, oLAYER 010/011/100/101/110 beginning at addresses 0/9/1017/2025/2697, oDONE=1 with the 2708 write, oREADY=0 afterwards.
- Random iVALID bubbles (~50%) -> identical address/data sequence, oWE count exactly 2709, no oWE in bubble-following cycles.
- Boundary check: words 8/9, 1016/1017, 2024/2025, 2696/2697 -> oLAYER switches exactly between each pair; iVALID held high after word 2708 -> no further oWE, oWADDR stays 2708.
- iSTART pulsed at word 500 in LOAD_ST -> ignored; next write is address 500.
- iRSTn asserted mid-load at word 1200 -> all outputs to reset values immediately; after release, iVALID alone causes no oWE; iSTART then restarts at address 0.
- From DONE_ST, iSTART -> oDONE=0 next cycle, reload from address 0 with oLAYER=010.
